uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmit serializer directly downstream of the system Tx control stage.
- Accepts one parallel byte per Data_Valid pulse and drives a serial line: start bit, data LSB-first, optional parity bit, stop bit.
- Reports Busy back to the Tx control stage, which expects Busy to rise on the cycle after its valid pulse and waits for Busy to fall before presenting the next byte.
- Clocked at the bit rate: one CLK cycle per bit.

Parameters:
- width, 8, data word width in bits (frame data length).

Ports:
- CLK  input  1  bit-rate clock.
- Reset  input  1  reset, asynchronous, active-low.
- P_DATA  input  width  parallel byte from Tx control.
- Data_Valid  input  1  single-cycle request; sampled only while Busy=0.
- PAR_EN  input  1  1 = insert parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- TX_OUT  output  1  serial line, idle high; registered.
- Busy  output  1  frame in progress; registered.

Behaviour:
- Reset (asynchronous, immediate, also mid-frame):
  - TX_OUT=1, Busy=0, state=IDLE.
  - Shift register, bit counter and latched parity config cleared.
  - No partial frame resumes after reset release.
- States:
  - IDLE: TX_OUT=1, Busy=0.
    - If Data_Valid=1 at an edge, latch P_DATA, PAR_EN and PAR_TYP, then go to START.
    - If Data_Valid=0, stay in IDLE.
  - START: TX_OUT=0, Busy=1. Bit counter=0. Next state is DATA.
  - DATA: TX_OUT=latched_data[cnt], LSB first; cnt increments each cycle.
    - When cnt=width-1: go to PARITY if latched PAR_EN=1, else go to STOP.
  - PARITY: TX_OUT = XOR of latched data, inverted when latched PAR_TYP=1. Next state is STOP.
  - STOP: TX_OUT=1, Busy=1. Next state is IDLE (Busy=0 after that edge).
- Latency: if Data_Valid is sampled at edge n, TX_OUT=0 and Busy=1 from edge n (visible in cycle n+1).
- Busy high-time:
  - 1+width+1 cycles without parity (10 for width=8).
  - 1+width+2 cycles with parity (11 for width=8).
- Back-to-back frames: Data_Valid is ignored while Busy=1, including during the STOP cycle. The minimum gap is therefore one IDLE cycle, so frame-to-frame spacing is 11 cycles without parity and 12 with parity.
- Input changes mid-frame: changes to P_DATA, PAR_EN or PAR_TYP while Busy=1 have no effect on the current frame.
- Data_Valid held high for several cycles in IDLE: exactly one frame is accepted. Re-acceptance is only possible after Busy falls and Data_Valid is still high.
- Bit counter: width $clog2(width); it must not wrap inside DATA.
- Illegal state encodings recover to IDLE with TX_OUT=1 and Busy=0.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants IDLE, START, DATA, PARITY, STOP (3-bit).
  - START_BIT=1'b0, STOP_BIT=1'b1.
  - PAR_EVEN=1'b0, PAR_ODD=1'b1.
- One sub-module is natural: uart_tx_parity. It is a combinational XOR-reduce of the latched word plus PAR_TYP select, reused later by the receiver parity checker.
- The FSM, shift/counter and output register stay in uart_tx_frame.

Test Plan:
- P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid:
  - TX_OUT sequence 0,1,0,1,0,0,1,0,1,1.
  - Busy high exactly 10 cycles, rising the cycle after Data_Valid.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0: data bits as above, parity bit=0, then stop=1; Busy high 11 cycles.
- P_DATA=0x07, PAR_EN=1:
  - PAR_TYP=0 gives parity bit=1.
  - PAR_TYP=1 gives parity bit=0.
- Back-to-back bytes:
  - Data_Valid pulsed for 0x3C; a second pulse with 0xFF is given while Busy=1 and must be ignored.
  - A pulse for 0x81 in the first IDLE cycle after Busy falls is accepted; its start bit appears exactly 11 cycles after the first start bit (PAR_EN=0).
- P_DATA changed to 0x00 and PAR_EN toggled during the DATA state of an 0xFF frame: transmitted bits remain all ones and the parity config is unchanged.
- Reset asserted in the 4th data bit: TX_OUT=1 and Busy=0 immediately, without waiting for a clock edge. After release the line stays idle until a new Data_Valid arrives.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line/parity constants,
// used by the transmit serializer and the receiver parity checker.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte handshake between the Tx control stage (master) and the serializer (slave).
interface uart_tx_frame_if #(
    parameter int width = 8
);
    logic [width-1:0] P_DATA;
    logic             Data_Valid;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic             TX_OUT;
    logic             Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_parity.sv
// Combinational parity generator: XOR-reduce of a data word, inverted for odd parity.
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int width = 8
) (
    input  logic [width-1:0] data,
    input  logic             par_typ,
    output logic             parity
);

    assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit serializer: start bit, data LSB-first, optional parity, stop bit.
// One CLK cycle per bit; TX_OUT and Busy are registered.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int width = 8
) (
    input  logic           CLK,
    input  logic           Reset,
    uart_tx_frame_if.slave bus
);

    localparam int                 CNT_W    = (width > 1) ? $clog2(width) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(width - 1);

    logic [2:0]       state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [width-1:0] data_q;
    logic             par_en_q, par_typ_q;
    logic             tx_q, next_tx;
    logic             busy_q, next_busy;
    logic             parity_bit;
    logic             accept;

    // Only an IDLE cycle can take a request; Data_Valid is don't-care while busy.
    assign accept = (state == IDLE) && bus.Data_Valid;

    uart_tx_parity #(.width(width)) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .parity  (parity_bit)
    );

    // Outputs are registered, so the combinational block computes the line value
    // belonging to the state being entered, not the current one.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state = IDLE;
        next_cnt   = cnt;
        next_tx    = STOP_BIT;
        next_busy  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Data_Valid) begin
                    next_state = START;
                    next_cnt   = '0;
                    next_tx    = START_BIT;
                    next_busy  = 1'b1;
                end
            end
            START: begin
                next_state = DATA;
                next_cnt   = '0;
                next_tx    = data_q[0];
                next_busy  = 1'b1;
            end
            DATA: begin
                next_busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    next_state = par_en_q ? PARITY : STOP;
                    next_tx    = par_en_q ? parity_bit : STOP_BIT;
                end else begin
                    next_state = DATA;
                    next_cnt   = cnt + CNT_W'(1);
                    next_tx    = data_q[next_cnt];
                end
            end
            PARITY: begin
                next_state = STOP;
                next_busy  = 1'b1;
            end
            STOP: begin
                next_cnt = '0;
            end
            default: begin
                next_cnt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            // NOTE: the latched word and config are reset too, so a frame cut short
            // by reset leaves nothing behind that a later frame could pick up.
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= STOP_BIT;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates on the same edge.
            state  <= next_state;
            cnt    <= next_cnt;
            tx_q   <= next_tx;
            busy_q <= next_busy;
            if (accept) begin
                data_q    <= bus.P_DATA;
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
            end
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frame table, hand-written
// back-to-back and reset sequences, and random frames against a frame model.
module tb_uart_tx_frame;

    localparam int W = 8;

    logic CLK = 1'b0;
    logic Reset;

    uart_tx_frame_if #(.width(W)) bus ();

    uart_tx_frame #(.width(W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;
    int frame_start = 0;

    always @(posedge CLK) cycle <= cycle + 1;

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [10:0] bits;   // bit i = i-th transmitted line value
        int          len;
        int          noise;  // 0 quiet, 1 P_DATA=0/config flipped/DV held, 2 random, 3 0xFF pulse
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame built straight from the framing rules.
    function automatic void build_frame(input logic [7:0] d, input logic pe, input logic pt,
                                        output logic [10:0] bits, output int len);
        int ones;
        ones = $countones(d);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++) bits[i+1] = d[i];
        if (pe) begin
            bits[W+1] = ((ones % 2) != 0) ^ pt;
            bits[W+2] = 1'b1;
            len = W + 3;
        end else begin
            bits[W+1] = 1'b1;
            len = W + 2;
        end
    endfunction

    task automatic check_idle(input string name);
        check({name, " idle busy"}, 32'(bus.Busy), 32'd0);
        check({name, " idle tx"}, 32'(bus.TX_OUT), 32'd1);
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [10:0] bits, input int len,
                             input int noise);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Data_Valid = 1'b1;
        @(negedge CLK);
        frame_start = cycle;
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s bit%0d", name, i), 32'(bus.TX_OUT), 32'(bits[i]));
            check($sformatf("%s busy%0d", name, i), 32'(bus.Busy), 32'd1);
            case (noise)
                1: begin
                    bus.P_DATA     = 8'h00;
                    bus.PAR_EN     = ~pe;
                    bus.PAR_TYP    = ~pt;
                    bus.Data_Valid = 1'b1;
                end
                2: begin
                    bus.P_DATA     = 8'($urandom);
                    bus.PAR_EN     = 1'($urandom_range(1));
                    bus.PAR_TYP    = 1'($urandom_range(1));
                    bus.Data_Valid = 1'($urandom_range(1));
                end
                3: begin
                    bus.P_DATA     = 8'hFF;
                    bus.Data_Valid = (i == 2);
                end
                default: bus.Data_Valid = 1'b0;
            endcase
            @(negedge CLK);
        end
        bus.Data_Valid = 1'b0;
        check_idle(name);
    endtask

    vec_t        vecs[6];
    logic [10:0] bits;
    int          len;
    int          s1;
    logic [7:0]  d;
    logic        pe, pt;

    initial begin
        vecs[0] = '{"A5 nopar",     8'hA5, 1'b0, 1'b0, 11'b01101001010, 10, 0};
        vecs[1] = '{"A5 even",      8'hA5, 1'b1, 1'b0, 11'b10101001010, 11, 0};
        vecs[2] = '{"07 even",      8'h07, 1'b1, 1'b0, 11'b11000001110, 11, 0};
        vecs[3] = '{"07 odd",       8'h07, 1'b1, 1'b1, 11'b10000001110, 11, 0};
        vecs[4] = '{"FF nopar chg", 8'hFF, 1'b0, 1'b0, 11'b01111111110, 10, 1};
        vecs[5] = '{"FF even chg",  8'hFF, 1'b1, 1'b0, 11'b10111111110, 11, 1};

        Reset          = 1'b0;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset tx", 32'(bus.TX_OUT), 32'd1);
        check("reset busy", 32'(bus.Busy), 32'd0);
        Reset = 1'b1;
        repeat (2) @(negedge CLK);
        check_idle("post reset");

        // Directed table, spec-derived constants.
        foreach (vecs[k])
            run_frame(vecs[k].name, vecs[k].data, vecs[k].pe, vecs[k].pt,
                      vecs[k].bits, vecs[k].len, vecs[k].noise);

        // Back-to-back: 0xFF pulse inside the 0x3C frame is ignored, 0x81 taken
        // in the first IDLE cycle.
        build_frame(8'h3C, 1'b0, 1'b0, bits, len);
        run_frame("b2b 3C", 8'h3C, 1'b0, 1'b0, bits, len, 3);
        s1 = frame_start;
        build_frame(8'h81, 1'b0, 1'b0, bits, len);
        run_frame("b2b 81", 8'h81, 1'b0, 1'b0, bits, len, 0);
        check("b2b spacing", 32'(frame_start - s1), 32'd11);

        // Reset in the 4th data bit of an 0xA5 frame (that bit is a 0).
        bus.P_DATA     = 8'hA5;
        bus.PAR_EN     = 1'b0;
        bus.Data_Valid = 1'b1;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst mid tx before", 32'(bus.TX_OUT), 32'd0);
        check("rst mid busy before", 32'(bus.Busy), 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("rst mid tx async", 32'(bus.TX_OUT), 32'd1);
        check("rst mid busy async", 32'(bus.Busy), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            check_idle($sformatf("after rst %0d", i));
        end
        build_frame(8'h5A, 1'b1, 1'b1, bits, len);
        run_frame("after rst 5A", 8'h5A, 1'b1, 1'b1, bits, len, 0);

        // Random frames with mid-frame input noise and random idle gaps.
        for (int k = 0; k < 40; k++) begin
            d  = 8'($urandom);
            pe = 1'($urandom_range(1));
            pt = 1'($urandom_range(1));
            build_frame(d, pe, pt, bits, len);
            run_frame($sformatf("rnd%0d %02h", k, d), d, pe, pt, bits, len, 2);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(negedge CLK);
                check_idle($sformatf("rnd%0d gap", k));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
